instr_encoder: RTL and testbench

- Streaming RISC-V RV32I instruction encoder: packs opcode, register, funct and immediate fields into a 32-bit instruction word.
- Uses the same format codes and bit placements that the decode path uses to extract immediates.
- Feeds the instruction-memory loader and self-test sequencers; encode→decode round-trip must be lossless for in-range fields.
- Valid/ready on both sides, one registered output stage with skid buffer, running word-address counter.

---
 rtl/instr_encoder.sv | 113 +++++++++++
 tb/tb_instr_encoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: RV32I field packer with a registered output stage, one-entry skid buffer and word-address counter.
// Optional immediate range/alignment checking is enabled with `define INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
   parameter int WIDTH  = 32,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [WIDTH-1:0]  in_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_instr,
   output logic              out_err,
   output logic [ADDR_W-1:0] out_addr,
   output logic [7:0]        err_count
);
   localparam logic [2:0] F_I = 3'b000, F_S = 3'b001, F_SB = 3'b010, F_U = 3'b011;
   localparam logic [2:0] F_UJ = 3'b100, F_SH = 3'b101, F_BAD = 3'b110, F_R = 3'b111;

   logic [WIDTH-1:0]  enc, out_instr_q, out_instr_d, skid_instr_q, skid_instr_d;
   logic              enc_err, rng_err, out_v_q, out_v_d, out_err_q, out_err_d;
   logic              skid_v_q, skid_v_d, skid_err_q, skid_err_d, acc, xfer, load;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        errc_q, errc_d;

   always_comb begin
      enc = '0;
      case (in_fmt)
         F_I:     enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         F_S:     enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
         F_SB:    enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode};
         F_U:     enc = {in_imm[31:12], in_rd, in_opcode};
         F_UJ:    enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
         F_SH:    enc = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
         F_R:     enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         default: enc = '0;
      endcase
   end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
   logic signed [WIDTH-1:0] simm;
   assign simm = $signed(in_imm);
   always_comb begin
      rng_err = 1'b0;
      case (in_fmt)
         F_I, F_S: rng_err = simm < -2048 || simm > 2047;
         F_SB:     rng_err = simm < -4096 || simm > 4094 || in_imm[0];
         F_UJ:     rng_err = simm < -(1 << 20) || simm > (1 << 20) - 2 || in_imm[0];
         F_U:      rng_err = in_imm[11:0] != '0;
         F_SH:     rng_err = in_imm[WIDTH-1:5] != '0;
         default:  rng_err = 1'b0;
      endcase
   end
`else
   assign rng_err = 1'b0;
`endif

   assign enc_err = (in_fmt == F_BAD) || rng_err;

   // rst gates in_ready so nothing is accepted while reset is held
   assign in_ready = !rst && !skid_v_q;
   assign acc      = in_valid && in_ready;
   assign xfer     = out_v_q && out_ready;
   assign load     = !out_v_q || out_ready;

   always_comb begin
      out_v_d      = load ? (skid_v_q || acc) : out_v_q;
      out_instr_d  = !load ? out_instr_q : skid_v_q ? skid_instr_q : acc ? enc : out_instr_q;
      out_err_d    = !load ? out_err_q : skid_v_q ? skid_err_q : acc ? enc_err : out_err_q;
      skid_v_d     = load ? 1'b0 : (skid_v_q || acc);
      skid_instr_d = (!load && acc) ? enc : skid_instr_q;
      skid_err_d   = (!load && acc) ? enc_err : skid_err_q;
      addr_d       = xfer ? addr_q + 1'b1 : addr_q;
      errc_d       = (xfer && out_err_q && errc_q != 8'hFF) ? errc_q + 8'd1 : errc_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_v_q      <= 1'b0;
         out_instr_q  <= '0;
         out_err_q    <= 1'b0;
         skid_v_q     <= 1'b0;
         skid_instr_q <= '0;
         skid_err_q   <= 1'b0;
         addr_q       <= '0;
         errc_q       <= '0;
      end else begin
         out_v_q      <= out_v_d;
         out_instr_q  <= out_instr_d;
         out_err_q    <= out_err_d;
         skid_v_q     <= skid_v_d;
         skid_instr_q <= skid_instr_d;
         skid_err_q   <= skid_err_d;
         addr_q       <= addr_d;
         errc_q       <= errc_d;
      end
   end

   assign out_valid = out_v_q;
   assign out_instr = out_instr_q;
   assign out_err   = out_err_q;
   assign out_addr  = addr_q;
   assign err_count = errc_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed-vector bench for instr_encoder; expected error flags follow INSTR_ENCODER_RANGE_CHECK_EN.
module tb_instr_encoder;
   logic        clk = 1'b0, rst = 1'b1;
   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_err;
   logic [2:0]  in_fmt = '0, in_funct3 = '0;
   logic [6:0]  in_opcode = '0, in_funct7 = '0;
   logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [31:0] in_imm = '0, out_instr;
   logic [9:0]  out_addr;
   logic [7:0]  err_count;
   int          n_tests = 0, n_fail = 0;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
   localparam int RC = 1;
`else
   localparam int RC = 0;
`endif

   typedef struct {
      int fmt, opc, rd, rs1, rs2, f3, f7;
      logic [31:0] imm, exp;
      int ef, er;
   } vec_t;
   vec_t v[19];

   instr_encoder #(.WIDTH(32), .ADDR_W(10)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err), .out_addr(out_addr),
      .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic init_vecs;
      v[0]  = '{0, 'h13, 1, 0, 0, 0, 0,    32'hFFFFFFFF, 32'hFFF00093, 0, 0};
      v[1]  = '{1, 'h23, 0, 3, 2, 2, 0,    32'h00000008, 32'h0021A423, 0, 0};
      v[2]  = '{2, 'h63, 0, 0, 0, 0, 0,    32'hFFFFFFFC, 32'hFE000EE3, 0, 0};
      v[3]  = '{3, 'h37, 5, 0, 0, 0, 0,    32'h12345000, 32'h123452B7, 0, 0};
      v[4]  = '{4, 'h6F, 1, 0, 0, 0, 0,    32'h00000800, 32'h001000EF, 0, 0};
      v[5]  = '{5, 'h13, 1, 2, 0, 1, 0,    32'h00000003, 32'h00311093, 0, 0};
      v[6]  = '{5, 'h13, 1, 2, 0, 5, 'h20, 32'h00000003, 32'h40315093, 0, 0};
      v[7]  = '{7, 'h33, 3, 1, 2, 0, 0,    32'hDEADBEEF, 32'h002081B3, 0, 0};
      v[8]  = '{7, 'h33, 3, 1, 2, 0, 'h20, 32'h00000000, 32'h402081B3, 0, 0};
      v[9]  = '{6, 'h13, 1, 2, 3, 0, 0,    32'h00000005, 32'h00000000, 1, 0};
      v[10] = '{0, 'h13, 1, 0, 0, 0, 0,    32'h00000800, 32'h80000093, 0, 1};
      v[11] = '{2, 'h63, 0, 0, 0, 0, 0,    32'h00000006, 32'h00000363, 0, 0};
      v[12] = '{2, 'h63, 0, 0, 0, 0, 0,    32'h00000005, 32'h00000263, 0, 1};
      v[13] = '{3, 'h37, 5, 0, 0, 0, 0,    32'h12345678, 32'h123452B7, 0, 1};
      v[14] = '{4, 'h6F, 1, 0, 0, 0, 0,    32'h00100000, 32'h800000EF, 0, 1};
      v[15] = '{5, 'h13, 1, 2, 0, 1, 0,    32'h00000020, 32'h00011093, 0, 1};
      v[16] = '{0, 'h13, 1, 0, 0, 0, 0,    32'hFFFFF800, 32'h80000093, 0, 0};
      v[17] = '{1, 'h23, 0, 0, 0, 2, 0,    32'hFFFFF7FF, 32'h7E002FA3, 0, 1};
      v[18] = '{4, 'h6F, 1, 0, 0, 0, 0,    32'hFFF00000, 32'h800000EF, 0, 0};
   endtask

   task automatic drive(input vec_t x);
      in_fmt = 3'(x.fmt); in_opcode = 7'(x.opc); in_rd = 5'(x.rd); in_rs1 = 5'(x.rs1);
      in_rs2 = 5'(x.rs2); in_funct3 = 3'(x.f3); in_funct7 = 7'(x.f7); in_imm = x.imm;
   endtask

   task automatic pulse_reset;
      rst = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_tests++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
      n_tests++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b want 0", out_err); end
      n_tests++; if (out_addr !== 10'd0) begin n_fail++; $display("FAIL reset_out_addr: got %0d want 0", out_addr); end
      n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_held: got %b want 0", in_ready); end
      rst = 1'b0;
      @(posedge clk); #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_release: got %b want 1", in_ready); end
   endtask

   task automatic test_encode_stream;
      logic [9:0] ea = 10'd0;
      logic [7:0] ec = 8'd0;
      logic       ee;
      out_ready = 1'b1;
      for (int i = 0; i < 19; i++) begin
         drive(v[i]); in_valid = 1'b1;
         @(posedge clk); #1;
         ee = (v[i].ef | (v[i].er & RC)) != 0;
         n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL enc%0d_valid: got %b want 1", i, out_valid); end
         n_tests++; if (out_instr !== v[i].exp) begin n_fail++; $display("FAIL enc%0d_instr: got %h want %h", i, out_instr, v[i].exp); end
         n_tests++; if (out_err !== ee) begin n_fail++; $display("FAIL enc%0d_err: got %b want %b", i, out_err, ee); end
         n_tests++; if (out_addr !== ea) begin n_fail++; $display("FAIL enc%0d_addr: got %0d want %0d", i, out_addr, ea); end
         n_tests++; if (err_count !== ec) begin n_fail++; $display("FAIL enc%0d_err_count: got %0d want %0d", i, err_count, ec); end
         ea++; ec = ec + 8'(ee);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL enc_drain_valid: got %b want 0", out_valid); end
      n_tests++; if (out_addr !== ea) begin n_fail++; $display("FAIL enc_drain_addr: got %0d want %0d", out_addr, ea); end
      n_tests++; if (err_count !== ec) begin n_fail++; $display("FAIL enc_drain_err_count: got %0d want %0d", err_count, ec); end
   endtask

   task automatic test_backpressure;
      logic [31:0] gi[4];
      logic [9:0]  ga[4];
      int sent = 0, got = 0;
      logic acc;
      pulse_reset();
      out_ready = 1'b0;
      drive(v[0]); in_valid = 1'b1;
      @(posedge clk); #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after1: got %b want 1", in_ready); end
      drive(v[1]);
      @(posedge clk); #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_after2: got %b want 0", in_ready); end
      drive(v[2]); sent = 2;
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_stall: got %b want 0", in_ready); end
      n_tests++; if (out_instr !== v[0].exp) begin n_fail++; $display("FAIL bp_hold_instr: got %h want %h", out_instr, v[0].exp); end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && got < 4; c++) begin
         if (out_valid) begin gi[got] = out_instr; ga[got] = out_addr; got++; end
         acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) begin
            sent++;
            if (sent < 4) drive(v[sent]); else in_valid = 1'b0;
         end
      end
      n_tests++; if (got !== 4) begin n_fail++; $display("FAIL bp_word_count: got %0d want 4", got); end
      for (int k = 0; k < got; k++) begin
         n_tests++; if (gi[k] !== v[k].exp) begin n_fail++; $display("FAIL bp_order%0d_instr: got %h want %h", k, gi[k], v[k].exp); end
         n_tests++; if (ga[k] !== 10'(k)) begin n_fail++; $display("FAIL bp_order%0d_addr: got %0d want %0d", k, ga[k], k); end
      end
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
   endtask

   task automatic test_saturate_wrap;
      int xfers = 0;
      pulse_reset();
      out_ready = 1'b1;
      drive(v[9]); in_valid = 1'b1;
      for (int i = 0; i < 1030; i++) begin
         @(posedge clk); #1;
         if (out_valid) xfers++;
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      n_tests++; if (xfers !== 1030) begin n_fail++; $display("FAIL sat_throughput: got %0d want 1030", xfers); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sat_drain_valid: got %b want 0", out_valid); end
      n_tests++; if (out_addr !== 10'd6) begin n_fail++; $display("FAIL sat_addr_wrap: got %0d want 6", out_addr); end
      n_tests++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_err_count: got %0d want 255", err_count); end
   endtask

   task automatic test_reset_midstream;
      out_ready = 1'b0;
      drive(v[9]); in_valid = 1'b1;
      @(posedge clk); #1;
      drive(v[0]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_pre_full: got valid=%b ready=%b want valid=1 ready=0", out_valid, in_ready); end
      rst = 1'b1;
      #1;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
      n_tests++; if (out_addr !== 10'd0 || err_count !== 8'd0) begin n_fail++; $display("FAIL mid_counters: got addr=%0d ec=%0d want 0 0", out_addr, err_count); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_post_release: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready); end
      out_ready = 1'b1;
      drive(v[1]); in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_tests++; if (out_valid !== 1'b1 || out_instr !== v[1].exp) begin n_fail++; $display("FAIL mid_next_word: got valid=%b instr=%h want 1 %h", out_valid, out_instr, v[1].exp); end
      n_tests++; if (out_addr !== 10'd0) begin n_fail++; $display("FAIL mid_next_addr: got %0d want 0", out_addr); end
      n_tests++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL mid_next_err_count: got %0d want 0", err_count); end
   endtask

   initial begin
      init_vecs();
      test_reset();
      test_encode_stream();
      test_backpressure();
      test_saturate_wrap();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
